// File: rtl/counting_gen.sv
// counting_gen: 01/10/11 run-length symbol source on a valid/ready stream.
// Optional COUNTING_GEN_REPEAT_EN: rep port, repeated passes with 00 gap beats.
module counting_gen #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len1,
  input  logic [LEN_W-1:0] len2,
  input  logic [LEN_W-1:0] len3,
`ifdef COUNTING_GEN_REPEAT_EN
  input  logic [LEN_W-1:0] rep,
`endif
  input  logic             num_ready,
  output logic             num_valid,
  output logic [1:0]       num,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, S1, S2, S3, GAP, FIN
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len1_q, len1_d;
  logic [LEN_W-1:0] len2_q, len2_d;
  logic [LEN_W-1:0] len3_q, len3_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [1:0]       num_q, num_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef COUNTING_GEN_REPEAT_EN
  logic [LEN_W-1:0] rep_q, rep_d;
`endif

  state_t pass_end, from_s1, from_s2, from_s3;
  logic   accept, last, load_cnt;

  // Skip chain: first non-empty segment at or after a given one.
  always_comb begin
`ifdef COUNTING_GEN_REPEAT_EN
    pass_end = (rep_q != '0) ? GAP : FIN;
`else
    pass_end = FIN;
`endif
    from_s3 = (len3_q != '0) ? S3 : pass_end;
    from_s2 = (len2_q != '0) ? S2 : from_s3;
    from_s1 = (len1_q != '0) ? S1 : from_s2;
  end

  assign accept = valid_q & num_ready;
  assign last   = (cnt_q == LEN_W'(1));

  always_comb begin
    state_d  = state_q;
    len1_d   = len1_q;
    len2_d   = len2_q;
    len3_d   = len3_q;
    cnt_d    = cnt_q;
    load_cnt = 1'b0;
`ifdef COUNTING_GEN_REPEAT_EN
    rep_d    = rep_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len1_d  = len1;
          len2_d  = len2;
          len3_d  = len3;
`ifdef COUNTING_GEN_REPEAT_EN
          rep_d   = rep;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d  = from_s1;
        load_cnt = 1'b1;
      end
      S1: begin
        if (accept) begin
          if (last) begin
            state_d  = from_s2;
            load_cnt = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      S2: begin
        if (accept) begin
          if (last) begin
            state_d  = from_s3;
            load_cnt = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      S3: begin
        if (accept) begin
          if (last) begin
            state_d  = pass_end;
            load_cnt = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      GAP: begin
        if (accept) begin
          state_d  = from_s1;
          load_cnt = 1'b1;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load_cnt) begin
      unique case (state_d)
        S1:      cnt_d = len1_q;
        S2:      cnt_d = len2_q;
        S3:      cnt_d = len3_q;
        default: cnt_d = '0;
      endcase
    end

`ifdef COUNTING_GEN_REPEAT_EN
    if (state_d == GAP && state_q != GAP)
      rep_d = rep_q - LEN_W'(1);
`endif
  end

  // Outputs are registered copies decoded from the next state.
  always_comb begin
    valid_d = 1'b0;
    num_d   = 2'b00;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_d == S1):   begin valid_d = 1'b1; num_d = 2'b01; end
      (state_d == S2):   begin valid_d = 1'b1; num_d = 2'b10; end
      (state_d == S3):   begin valid_d = 1'b1; num_d = 2'b11; end
      (state_d == GAP):  valid_d = 1'b1;
      (state_d == FIN):  done_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != IDLE) && (state_d != FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len1_q  <= '0;
      len2_q  <= '0;
      len3_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      num_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COUNTING_GEN_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len1_q  <= len1_d;
      len2_q  <= len2_d;
      len3_q  <= len3_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      num_q   <= num_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef COUNTING_GEN_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign num_valid = valid_q;
  assign num       = num_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_counting_gen.sv
// tb_counting_gen: directed checks of the counting_gen burst source.
// Define COUNTING_GEN_REPEAT_EN to also exercise repeated passes.
module tb_counting_gen;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len1, len2, len3;
`ifdef COUNTING_GEN_REPEAT_EN
  logic [LEN_W-1:0] rep;
`endif
  logic             num_ready;
  logic             num_valid;
  logic [1:0]       num;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  counting_gen #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len1      (len1),
    .len2      (len2),
    .len3      (len3),
`ifdef COUNTING_GEN_REPEAT_EN
    .rep       (rep),
`endif
    .num_ready (num_ready),
    .num_valid (num_valid),
    .num       (num),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [1:0] n, input logic b,
                         input logic d);
    chk({tag, ".valid"}, 32'(num_valid), 32'(v));
    chk({tag, ".num"},   32'(num),       32'(n));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".done"},  32'(done),      32'(d));
  endtask

  task automatic go(input logic [3:0] a, input logic [3:0] b,
                    input logic [3:0] c);
    len1  = a;
    len2  = b;
    len3  = c;
    start = 1'b1;
    step();
    start = 1'b0;
    len1  = '1;
    len2  = '1;
    len3  = '1;
  endtask

  logic [1:0] exp_b [6];
  logic [1:0] pre_num;
  logic       pre_valid;
  int         n_acc;
  int         n_done;

  initial begin
    exp_b = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
    rst_n = 1'b0;
    start = 1'b0;
    len1 = '0; len2 = '0; len3 = '0;
`ifdef COUNTING_GEN_REPEAT_EN
    rep = '0;
`endif
    num_ready = 1'b1;
    step();
    step();
    chk_out("reset", 1'b0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("idle", 1'b0, 2'b00, 1'b0, 1'b0);

    // basic burst 2,1,3
    go(4'd2, 4'd1, 4'd3);
    chk_out("basic.load", 1'b0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out($sformatf("basic.b%0d", i), 1'b1, exp_b[i], 1'b1, 1'b0);
    end
    step();
    chk_out("basic.fin", 1'b0, 2'b00, 1'b0, 1'b1);
    step();
    chk_out("basic.idle", 1'b0, 2'b00, 1'b0, 1'b0);

    // backpressure, ready alternating 1,0,...
    go(4'd2, 4'd1, 4'd3);
    n_acc  = 0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      num_ready = (c % 2 == 0);
      pre_num   = num;
      pre_valid = num_valid;
      if (num_valid && num_ready) begin
        if (n_acc < 6)
          chk($sformatf("bp.acc%0d", n_acc), 32'(num), 32'(exp_b[n_acc]));
        n_acc++;
      end
      step();
      if (pre_valid && !num_ready) begin
        chk($sformatf("bp.hold_n%0d", c), 32'(num), 32'(pre_num));
        chk($sformatf("bp.hold_v%0d", c), 32'(num_valid), 32'(1));
      end
      if (done) n_done++;
    end
    num_ready = 1'b1;
    chk("bp.beats", 32'(n_acc), 32'd6);
    chk("bp.dones", 32'(n_done), 32'd1);

    // zero-length middle skip: 0,2,0
    go(4'd0, 4'd2, 4'd0);
    step();
    chk_out("z.b0", 1'b1, 2'b10, 1'b1, 1'b0);
    step();
    chk_out("z.b1", 1'b1, 2'b10, 1'b1, 1'b0);
    step();
    chk_out("z.fin", 1'b0, 2'b00, 1'b0, 1'b1);
    step();

    // all zero
    go(4'd0, 4'd0, 4'd0);
    chk_out("z0.load", 1'b0, 2'b00, 1'b1, 1'b0);
    step();
    chk_out("z0.fin", 1'b0, 2'b00, 1'b0, 1'b1);
    step();
    chk_out("z0.idle", 1'b0, 2'b00, 1'b0, 1'b0);

    // reset during S2 of 3,3,3
    go(4'd3, 4'd3, 4'd3);
    for (int i = 0; i < 4; i++) step();
    chk_out("rst.s2", 1'b1, 2'b10, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    chk_out("rst.abort", 1'b0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("rst.after", 1'b0, 2'b00, 1'b0, 1'b0);

    // start while busy and during FIN is dropped
    go(4'd1, 4'd1, 4'd1);
    start = 1'b1;
    len1 = 4'd5; len2 = 4'd5; len3 = 4'd5;
    step();
    chk_out("drop.b0", 1'b1, 2'b01, 1'b1, 1'b0);
    step();
    chk_out("drop.b1", 1'b1, 2'b10, 1'b1, 1'b0);
    start = 1'b0;
    step();
    chk_out("drop.b2", 1'b1, 2'b11, 1'b1, 1'b0);
    step();
    chk_out("drop.fin", 1'b0, 2'b00, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("drop.idle", 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    chk_out("drop.idle2", 1'b0, 2'b00, 1'b0, 1'b0);

`ifdef COUNTING_GEN_REPEAT_EN
    begin
      logic [1:0] exp_r [7];
      exp_r = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
      rep = 4'd1;
      go(4'd1, 4'd1, 4'd1);
      rep = 4'd0;
      for (int i = 0; i < 7; i++) begin
        step();
        chk_out($sformatf("rep.b%0d", i), 1'b1, exp_r[i], 1'b1, 1'b0);
      end
      step();
      chk_out("rep.fin", 1'b0, 2'b00, 1'b0, 1'b1);
      step();
      chk_out("rep.idle", 1'b0, 2'b00, 1'b0, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
